// File: rtl/checkout_arbiter.sv
// Two-lane checkout controller: round-robin arbitration of lane requests onto one shared
// item-display datapath, with display dwell, stolen-item alarm and saturating sale/discount tallies.
module checkout_arbiter #(
  parameter int unsigned DWELL = 4,
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0,
  input  logic [3:0]       upc0,
  input  logic             req1,
  input  logic [3:0]       upc1,
  input  logic             clr_alarm,
  input  logic             stolen,
  input  logic             discount,
  output logic [3:0]       sel_upc,
  output logic             disp_en,
  output logic             gnt0,
  output logic             gnt1,
  output logic             busy,
  output logic             alarm,
  output logic             err,
  output logic [CNT_W-1:0] sale_count,
  output logic [CNT_W-1:0] disc_count,
  output logic [1:0]       dbg_state
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_SHOW  = 2'd2,
    ST_ALARM = 2'd3
  } state_e;

  localparam logic [CNT_W-1:0] CNT_MAX    = '1;
  localparam logic [CNT_W-1:0] CNT_ONE    = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [7:0]       DWELL_LAST = 8'(DWELL - 1);

  state_e           state_q, state_d;
  logic [3:0]       upc_q, upc_d;
  logic             lane_q, lane_d;
  logic             last_q, last_d;
  logic [7:0]       timer_q, timer_d;
  logic [CNT_W-1:0] sale_q, sale_d;
  logic [CNT_W-1:0] disc_q, disc_d;
  logic             code_ok;

  // Item select values 3'b010 and 3'b111 have no decoder entry.
  assign code_ok = (upc_q[2:0] != 3'b010) && (upc_q[2:0] != 3'b111);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      upc_q   <= 4'h0;
      lane_q  <= 1'b0;
      last_q  <= 1'b1;
      timer_q <= 8'd0;
      sale_q  <= '0;
      disc_q  <= '0;
    end else begin
      state_q <= state_d;
      upc_q   <= upc_d;
      lane_q  <= lane_d;
      last_q  <= last_d;
      timer_q <= timer_d;
      sale_q  <= sale_d;
      disc_q  <= disc_d;
    end
  end

  // Request handshake: a lane holds req with a stable upc until it sees its one-cycle gnt,
  // and a req still high in a later IDLE cycle counts as a fresh request. last_q records the
  // most recently granted lane (reset value 1 so lane 0 is favoured first).
  always_comb begin
    state_d = state_q;
    upc_d   = upc_q;
    lane_d  = lane_q;
    last_d  = last_q;
    timer_d = timer_q;
    sale_d  = sale_q;
    disc_d  = disc_q;
    case (state_q)
      ST_IDLE: begin
        if (req0 || req1) begin
          if (req0 && req1) lane_d = ~last_q;
          else              lane_d = req1;
          last_d  = lane_d;
          upc_d   = lane_d ? upc1 : upc0;
          state_d = ST_LOAD;
        end
      end
      ST_LOAD: begin
        if (!code_ok) begin
          state_d = ST_IDLE;
        end else if (stolen) begin
          state_d = ST_ALARM;
        end else begin
          if (sale_q != CNT_MAX) sale_d = sale_q + CNT_ONE;
          if (discount && (disc_q != CNT_MAX)) disc_d = disc_q + CNT_ONE;
          timer_d = DWELL_LAST;
          state_d = ST_SHOW;
        end
      end
      ST_SHOW: begin
        if (timer_q == 8'd0) state_d = ST_IDLE;
        else                 timer_d = timer_q - 8'd1;
      end
      ST_ALARM: begin
        if (clr_alarm) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign gnt0       = (state_q == ST_LOAD) && !lane_q;
  assign gnt1       = (state_q == ST_LOAD) && lane_q;
  assign err        = (state_q == ST_LOAD) && !code_ok;
  assign disp_en    = ((state_q == ST_LOAD) && code_ok) || (state_q == ST_SHOW) ||
                      (state_q == ST_ALARM);
  assign busy       = (state_q != ST_IDLE);
  assign alarm      = (state_q == ST_ALARM);
  assign sel_upc    = upc_q;
  assign sale_count = sale_q;
  assign disc_count = disc_q;
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_checkout_arbiter.sv
// Bench for checkout_arbiter: vector table, hand-written multi-cycle sequences and a
// randomized run checked against a timeline-based reference model.
module tb_checkout_arbiter;

  localparam int DWELL = 4;
  localparam int CNT_W = 2;
  localparam int MAXC  = 3;

  localparam int K_INV    = 0;
  localparam int K_SALE   = 1;
  localparam int K_STOLEN = 2;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             req0, req1, clr_alarm;
  logic [3:0]       upc0, upc1;
  logic             stolen, discount;
  logic [3:0]       sel_upc;
  logic             disp_en, gnt0, gnt1, busy, alarm, err;
  logic [CNT_W-1:0] sale_count, disc_count;
  logic [1:0]       dbg_state;

  logic [15:0] stolen_tab;
  logic [15:0] disc_tab;

  int n_checks = 0;
  int n_pass   = 0;

  // Shared flag logic stand-in: purely combinational on sel_upc.
  assign stolen   = stolen_tab[sel_upc];
  assign discount = disc_tab[sel_upc];

  checkout_arbiter #(.DWELL(DWELL), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0(req0), .upc0(upc0), .req1(req1), .upc1(upc1),
    .clr_alarm(clr_alarm), .stolen(stolen), .discount(discount),
    .sel_upc(sel_upc), .disp_en(disp_en), .gnt0(gnt0), .gnt1(gnt1),
    .busy(busy), .alarm(alarm), .err(err),
    .sale_count(sale_count), .disc_count(disc_count), .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  typedef struct {
    int r0; int u0; int r1; int u1; int clr;
    int g0; int g1; int de; int er; int al; int bz; int sel; int sa; int di;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t v(int r0, int u0, int r1, int u1, int clr,
                             int g0, int g1, int de, int er, int al, int bz,
                             int sel, int sa, int di);
    vec_t t;
    t.r0 = r0; t.u0 = u0; t.r1 = r1; t.u1 = u1; t.clr = clr;
    t.g0 = g0; t.g1 = g1; t.de = de; t.er = er; t.al = al; t.bz = bz;
    t.sel = sel; t.sa = sa; t.di = di;
    return t;
  endfunction

  function automatic logic [13:0] pack(logic g0, logic g1, logic de, logic er, logic al,
                                       logic bz, logic [3:0] sel, logic [1:0] sa, logic [1:0] di);
    return {g0, g1, de, er, al, bz, sel, sa, di};
  endfunction

  function automatic logic [13:0] obs();
    return pack(gnt0, gnt1, disp_en, err, alarm, busy, sel_upc, sale_count, disc_count);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    req0 = 1'b0; req1 = 1'b0; clr_alarm = 1'b0; upc0 = 4'h0; upc1 = 4'h0;
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Reference model: one transaction at a time, described by its grant cycle and kind;
  // all outputs follow from the cycle offset since the grant.
  int         m_tx;
  int         m_kind;
  int         m_lane;
  int         m_last;
  logic [3:0] m_sel;
  bit         m_cleared;
  int         m_clr_cyc;
  int         m_sale;
  int         m_disc;

  task automatic model_reset();
    m_tx = -1; m_kind = K_SALE; m_lane = 0; m_last = 1; m_sel = 4'h0;
    m_cleared = 1'b0; m_clr_cyc = 0; m_sale = 0; m_disc = 0;
  endtask

  function automatic bit m_idle(int x);
    if (m_tx < 0) return 1'b1;
    if (m_kind == K_INV)  return x >= m_tx + 1;
    if (m_kind == K_SALE) return x >= m_tx + DWELL + 1;
    return m_cleared && (x >= m_clr_cyc);
  endfunction

  task automatic model_edge(input int c);
    bit was_idle;
    int w;
    was_idle = m_idle(c - 1);
    if (m_tx >= 0 && m_kind == K_STOLEN && !m_cleared && (c - 1 >= m_tx + 1) && clr_alarm) begin
      m_cleared = 1'b1;
      m_clr_cyc = c;
    end
    if (m_tx >= 0 && m_kind == K_SALE && c == m_tx + 1) begin
      if (m_sale < MAXC) m_sale++;
      if (disc_tab[m_sel] && m_disc < MAXC) m_disc++;
    end
    if (was_idle && (req0 || req1)) begin
      if (req0 && req1) w = 1 - m_last;
      else              w = req1 ? 1 : 0;
      m_last = w; m_lane = w; m_sel = w ? upc1 : upc0;
      m_tx = c; m_cleared = 1'b0;
      if (m_sel[2:0] == 3'd2 || m_sel[2:0] == 3'd7) m_kind = K_INV;
      else if (stolen_tab[m_sel])                 m_kind = K_STOLEN;
      else                                        m_kind = K_SALE;
    end
  endtask

  function automatic logic [13:0] model_exp(int c);
    bit g = 0, de = 0, er = 0, al = 0, bz = 0;
    int off;
    if (m_tx >= 0) begin
      off = c - m_tx;
      if (m_kind == K_INV) begin
        if (off == 0) begin g = 1; er = 1; bz = 1; end
      end else if (m_kind == K_SALE) begin
        if (off <= DWELL) begin bz = 1; de = 1; g = (off == 0); end
      end else begin
        if (off == 0) begin g = 1; de = 1; bz = 1; end
        else if (!m_cleared || c < m_clr_cyc) begin al = 1; de = 1; bz = 1; end
      end
    end
    return pack(g && m_lane == 0, g && m_lane == 1, de, er, al, bz, m_sel,
                2'(m_sale), 2'(m_disc));
  endfunction

  initial begin
    int last_c, ng, exp_lane;
    logic [13:0] e;

    stolen_tab = 16'h0002;
    disc_tab   = 16'h0038;
    req0 = 1'b0; req1 = 1'b0; clr_alarm = 1'b0; upc0 = 4'h0; upc1 = 4'h0;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check("reset_state", obs(), 0);
    rst_n = 1'b1;

    // Vector table: inputs for one cycle, then expected outputs after the following edge.
    vecs.push_back(v(1,0,0,0,0, 1,0,1,0,0,1, 0,0,0));
    for (int i = 0; i < 4; i++) vecs.push_back(v(0,0,0,0,0, 0,0,1,0,0,1, 0,1,0));
    vecs.push_back(v(0,0,0,0,0, 0,0,0,0,0,0, 0,1,0));
    vecs.push_back(v(1,2,0,0,0, 1,0,0,1,0,1, 2,1,0));
    vecs.push_back(v(0,2,0,0,0, 0,0,0,0,0,0, 2,1,0));
    vecs.push_back(v(1,15,0,0,0, 1,0,0,1,0,1, 15,1,0));
    vecs.push_back(v(0,15,0,0,0, 0,0,0,0,0,0, 15,1,0));
    vecs.push_back(v(0,0,1,1,0, 0,1,1,0,0,1, 1,1,0));
    for (int i = 0; i < 3; i++) vecs.push_back(v(1,3,0,1,0, 0,0,1,0,1,1, 1,1,0));
    vecs.push_back(v(1,3,0,0,1, 0,0,0,0,0,0, 1,1,0));
    vecs.push_back(v(1,3,0,0,0, 1,0,1,0,0,1, 3,1,0));
    for (int i = 0; i < 4; i++) vecs.push_back(v(0,3,0,0,0, 0,0,1,0,0,1, 3,2,1));
    vecs.push_back(v(0,3,0,0,1, 0,0,0,0,0,0, 3,2,1));
    vecs.push_back(v(0,3,0,0,0, 0,0,0,0,0,0, 3,2,1));

    for (int i = 0; i < vecs.size(); i++) begin
      req0 = vecs[i].r0[0]; upc0 = vecs[i].u0[3:0];
      req1 = vecs[i].r1[0]; upc1 = vecs[i].u1[3:0];
      clr_alarm = vecs[i].clr[0];
      step();
      e = pack(vecs[i].g0[0], vecs[i].g1[0], vecs[i].de[0], vecs[i].er[0], vecs[i].al[0],
               vecs[i].bz[0], vecs[i].sel[3:0], vecs[i].sa[1:0], vecs[i].di[1:0]);
      check($sformatf("vec%0d", i), obs(), e);
    end
    clr_alarm = 1'b0;

    // Long alarm hold with lane 0 pending, then clear.
    do_reset();
    req1 = 1'b1; upc1 = 4'h1;
    step();
    check("alarm_gnt1", {gnt0, gnt1}, 2'b01);
    req1 = 1'b0; req0 = 1'b1; upc0 = 4'h0;
    for (int i = 0; i < 20; i++) begin
      step();
      check("alarm_hold", {alarm, disp_en, gnt0, gnt1}, 4'b1100);
    end
    clr_alarm = 1'b1;
    step();
    clr_alarm = 1'b0;
    check("alarm_clear", {busy, alarm}, 2'b00);
    step();
    check("alarm_next_gnt0", {gnt0, gnt1}, 2'b10);
    check("alarm_counts", {sale_count, disc_count}, 4'b0000);
    req0 = 1'b0;
    repeat (DWELL + 2) step();
    check("alarm_after_sale", {sale_count, disc_count}, 4'b0100);

    // Both lanes hold requests: grants alternate with fixed spacing.
    do_reset();
    req0 = 1'b1; req1 = 1'b1; upc0 = 4'h0; upc1 = 4'h6;
    ng = 0; last_c = 0; exp_lane = 0;
    for (int c = 1; c <= 40; c++) begin
      step();
      check("gnt_exclusive", gnt0 & gnt1, 0);
      if (gnt0 || gnt1) begin
        check("alt_lane", gnt1, exp_lane);
        if (ng > 0) check("alt_gap", c - last_c, DWELL + 2);
        exp_lane = 1 - exp_lane; last_c = c; ng++;
      end
    end
    check("alt_count", ng, 7);
    check("alt_sat", {sale_count, disc_count}, {2'd3, 2'd0});
    req0 = 1'b0; req1 = 1'b0;
    repeat (DWELL + 2) step();

    // Discount tallies and sale saturation with a narrow counter.
    do_reset();
    begin
      logic [3:0] items [5];
      items[0] = 4'h4; items[1] = 4'h0; items[2] = 4'h5; items[3] = 4'h6; items[4] = 4'h3;
      for (int i = 0; i < 5; i++) begin
        req0 = 1'b1; upc0 = items[i];
        step();
        check("disc_gnt", gnt0, 1);
        req0 = 1'b0;
        repeat (DWELL + 1) step();
        if (i == 2) check("disc_mid", {sale_count, disc_count}, {2'd3, 2'd2});
      end
    end
    check("disc_final", {sale_count, disc_count}, {2'd3, 2'd3});

    // Asynchronous reset in SHOW and in ALARM.
    do_reset();
    req0 = 1'b1; upc0 = 4'h0;
    step();
    check("rs_gnt0", gnt0, 1);
    req0 = 1'b0;
    step(); step();
    check("rs_in_show", {busy, disp_en, sale_count}, {1'b1, 1'b1, 2'd1});
    rst_n = 1'b0;
    #1;
    check("rs_show_async", obs(), 0);
    req0 = 1'b1; req1 = 1'b1; upc0 = 4'h0; upc1 = 4'h6;
    @(negedge clk);
    rst_n = 1'b1;
    step();
    check("rs_show_first", {gnt0, gnt1}, 2'b10);
    req0 = 1'b0; req1 = 1'b0;
    repeat (DWELL + 2) step();
    req1 = 1'b1; upc1 = 4'h1;
    step();
    check("ra_gnt1", gnt1, 1);
    req1 = 1'b0;
    step(); step();
    check("ra_in_alarm", {alarm, busy}, 2'b11);
    rst_n = 1'b0;
    #1;
    check("ra_alarm_async", obs(), 0);
    req0 = 1'b1; req1 = 1'b1; upc0 = 4'h0; upc1 = 4'h6;
    @(negedge clk);
    rst_n = 1'b1;
    step();
    check("ra_first", {gnt0, gnt1}, 2'b10);
    req0 = 1'b0; req1 = 1'b0;
    repeat (DWELL + 2) step();

    // Randomized traffic against the reference model.
    for (int rnd = 0; rnd < 4; rnd++) begin
      stolen_tab = 16'h0000;
      disc_tab   = 16'($urandom);
      for (int i = 0; i < 16; i++) if ($urandom_range(0, 7) == 0) stolen_tab[i] = 1'b1;
      do_reset();
      model_reset();
      for (int c = 1; c <= 400; c++) begin
        @(posedge clk);
        model_edge(c);
        @(negedge clk);
        check($sformatf("rand%0d_c%0d", rnd, c), obs(), model_exp(c));
        if (req0 && gnt0) req0 = 1'b0;
        else if (!req0 && $urandom_range(0, 2) == 0) begin req0 = 1'b1; upc0 = 4'($urandom); end
        if (req1 && gnt1) req1 = 1'b0;
        else if (!req1 && $urandom_range(0, 2) == 0) begin req1 = 1'b1; upc1 = 4'($urandom); end
        clr_alarm = ($urandom_range(0, 5) == 0);
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/checkout_arbiter.md
Name: checkout_arbiter

Overview:
- Two-lane checkout controller that shares one item-display datapath between two requesting lanes.
- The shared datapath is the item-name decoder driving HEX5..HEX0 plus the stolen/discount flag logic.
- Per lane request: grants one lane (round-robin), drives its 4-bit UPC onto the shared datapath, holds the display for a dwell time, samples the flags, and tallies sales and discounts.
- A stolen item latches an alarm that holds the datapath until cleared.

Parameters:
DWELL, 4, display hold cycles in SHOW; legal range 1..255.
CNT_W, 8, width of sale_count and disc_count.

Ports:
clk  input  1  system clock, rising edge.
rst_n  input  1  asynchronous active-low reset.
req0  input  1  lane 0 request; held with upc0 stable until gnt0 seen.
upc0  input  4  lane 0 item code; [2:0] is item select, [3:0] feeds flag logic.
req1  input  1  lane 1 request.
upc1  input  4  lane 1 item code.
clr_alarm  input  1  operator alarm clear, level-sampled.
stolen  input  1  from shared flag logic, 1 = stolen, combinational on sel_upc.
discount  input  1  from shared flag logic, 1 = discounted, combinational on sel_upc.
sel_upc  output  4  UPC driven to shared datapath.
disp_en  output  1  1 = display shows item; 0 = top level blanks HEX (7'b1111111).
gnt0  output  1  one-cycle grant pulse to lane 0.
gnt1  output  1  one-cycle grant pulse to lane 1.
busy  output  1  high in any state except IDLE.
alarm  output  1  high in ALARM.
err  output  1  one-cycle pulse on invalid item code.
sale_count  output  CNT_W  accepted non-stolen items, saturating.
disc_count  output  CNT_W  accepted discounted items, saturating.

Behaviour:
- Reset (async, rst_n=0):
  - State IDLE; all outputs 0 (sel_upc=4'h0, counters 0).
  - Round-robin pointer favours lane 0.
  - Takes effect immediately, in any state (SHOW, ALARM, etc.).
- States:
  - IDLE: disp_en=0. If any req is high at an edge, arbitrate; winner's upc is latched into sel_upc; go to LOAD.
    - Both requesting: the lane not most recently granted wins; the pointer then flips to the other lane.
    - One requesting: that lane wins regardless of pointer; pointer set to the other lane.
  - LOAD (exactly 1 cycle): registered gnt of winner high for this cycle only.
    - Valid code: disp_en=1.
    - Invalid code (upc[2:0] = 3'b010 or 3'b111, no decoder entry): disp_en=0, err=1 this cycle, counters unchanged, next state IDLE.
    - Valid code, stolen=1 at end of LOAD: go to ALARM; counters unchanged.
    - Valid code, stolen=0: sale_count+1; if discount=1 also disc_count+1; go to SHOW with timer loaded to DWELL-1.
  - SHOW: disp_en=1, sel_upc held. Timer decrements each cycle; at 0 go to IDLE. SHOW lasts exactly DWELL cycles.
  - ALARM: alarm=1, disp_en=1, sel_upc held. No grants; requests stay pending. clr_alarm=1 at an edge -> IDLE.
- Timing:
  - Valid non-stolen item occupies IDLE(1) + LOAD(1) + SHOW(DWELL) cycles.
  - Earliest back-to-back grant: DWELL+2 cycles after the previous one.
- Requester protocol: drop req in the cycle after seeing gnt. A req still high in the next IDLE is a new request.
- clr_alarm outside ALARM is ignored.
- Counters saturate at 2^CNT_W-1 and never wrap. A saturated sale_count does not block disc_count increments.
- busy = (state != IDLE).
- gnt0/gnt1 are never both high.

Test Plan:
- Reset, then req0=1 with upc0=4'b0000, DWELL=4 -> gnt0 pulses 1 cycle; disp_en=1 for 5 cycles (LOAD+4 SHOW) with sel_upc=0; sale_count=1; busy low after.
- req0=req1=1 held continuously, valid non-stolen codes -> grants alternate gnt0,gnt1,gnt0,...; grant spacing exactly DWELL+2=6 cycles.
- Datapath model returns stolen=1 for upc1=4'b0001 -> gnt1 pulse, then alarm=1 and disp_en=1 held 20 cycles while req0 pending with no gnt0; clr_alarm=1 -> IDLE, then gnt0 granted next; counters unchanged by the stolen item.
- upc0=4'b0010 and 4'b1111 -> gnt0 pulse with err=1 the same cycle; disp_en stays 0; counters unchanged; back to IDLE in 2 cycles.
- Discount=1 on 3 items, CNT_W=2 with 5 valid items -> disc_count=3, sale_count saturates at 3.
- Assert rst_n=0 mid-SHOW and mid-ALARM -> all outputs 0 asynchronously, before the next clk edge; first grant after release goes to lane 0 when both request.
